// File: rtl/vga_pkg.sv
// Shared display-path definitions.
//   COORD_W        : width of the hdata/vdata coordinates used by every painter
//   FCNT_W         : width of the completed-frame counter
//   DEF_*          : default 800x600@72 raster timing (50 MHz pixel clock)
//   vga_sync_t     : {hsync, vsync, de} bundle carried through the sync delay line
//   sync_idle()    : inactive value of a vga_sync_t for the given sync polarities
package vga_pkg;

  localparam int COORD_W = 12;
  localparam int FCNT_W  = 16;

  localparam int DEF_HSIZE = 800;
  localparam int DEF_HFP   = 856;
  localparam int DEF_HSP   = 976;
  localparam int DEF_HMAX  = 1040;
  localparam int DEF_VSIZE = 600;
  localparam int DEF_VFP   = 637;
  localparam int DEF_VSP   = 643;
  localparam int DEF_VMAX  = 666;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } vga_sync_t;

  function automatic vga_sync_t sync_idle(input logic hspp, input logic vspp);
    vga_sync_t s;
    s.hsync = ~hspp;
    s.vsync = ~vspp;
    s.de    = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus between the timing generator and its consumers.
//   pixel_ce    : pixel advance enable (driven by the consumer side)
//   hdata/vdata : current raster coordinate
//   hsync/vsync/data_enable : delayed sync and visible-area flag
//   line_start/frame_start  : one-clk strobes at the start of a line / frame
//   frame_count : completed-frame counter
// master = timing generator, slave = consumer.
interface vga_timing_gen_if
  import vga_pkg::*;
();

  logic               pixel_ce;
  logic [COORD_W-1:0] hdata;
  logic [COORD_W-1:0] vdata;
  logic               hsync;
  logic               vsync;
  logic               data_enable;
  logic               line_start;
  logic               frame_start;
  logic [FCNT_W-1:0]  frame_count;

  modport master (
    input  pixel_ce,
    output hdata, vdata, hsync, vsync, data_enable,
           line_start, frame_start, frame_count
  );

  modport slave (
    output pixel_ce,
    input  hdata, vdata, hsync, vsync, data_enable,
           line_start, frame_start, frame_count
  );

endinterface

// File: rtl/vga_sync_delay.sv
// Clock-enable gated shift register for the {hsync, vsync, de} bundle, used to
// keep sync aligned with the painters' registered RGB.
//   clk, reset_n : clock and synchronous active-low reset (stages -> RST_VAL)
//   ce           : shift enable (pixel advance)
//   din / dout   : bundle in / bundle after STAGES enabled shifts
// STAGES=0 is a pure wire.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int        STAGES  = 1,
  parameter vga_sync_t RST_VAL = '0
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      ce,
  input  vga_sync_t din,
  output vga_sync_t dout
);

  if (STAGES == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, reset_n, ce};
    assign dout = din;
  end else begin : g_shift
    vga_sync_t stage_p [STAGES];

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int i = 0; i < STAGES; i++) stage_p[i] <= RST_VAL;
      end else if (ce) begin
        stage_p[0] <= din;
        for (int i = 1; i < STAGES; i++) stage_p[i] <= stage_p[i-1];
      end
    end

    assign dout = stage_p[STAGES-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source. Free-running pixel/line counters advanced by
// pixel_ce produce the painter coordinates; sync and visible-area flags are
// decoded from the counters and delayed by SYNC_DELAY pixel steps.
//   clk     : system clock
//   reset_n : synchronous active-low reset (counters, strobes, delay line)
//   bus     : vga_timing_gen_if master (pixel_ce in; coordinates, sync,
//             strobes and frame_count out)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HSIZE      = DEF_HSIZE,
  parameter int HFP        = DEF_HFP,
  parameter int HSP        = DEF_HSP,
  parameter int HMAX       = DEF_HMAX,
  parameter int VSIZE      = DEF_VSIZE,
  parameter int VFP        = DEF_VFP,
  parameter int VSP        = DEF_VSP,
  parameter int VMAX       = DEF_VMAX,
  parameter bit HSPP       = 1'b1,
  parameter bit VSPP       = 1'b1,
  parameter int SYNC_DELAY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  vga_timing_gen_if.master bus
);

  localparam vga_sync_t SYNC_IDLE = sync_idle(HSPP, VSPP);

  if (!(HSIZE <= HFP && HFP < HSP && HSP <= HMAX && HMAX <= 4096 &&
        VSIZE <= VFP && VFP < VSP && VSP <= VMAX && VMAX <= 4096 &&
        SYNC_DELAY >= 0 && SYNC_DELAY <= 4)) begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [COORD_W-1:0] hcnt;
  logic [COORD_W-1:0] vcnt;
  logic [FCNT_W-1:0]  fcnt;
  logic               line_q;
  logic               frame_q;
  logic               h_last;
  logic               v_last;
  vga_sync_t          sync_raw;
  vga_sync_t          sync_dly;

  assign h_last = (hcnt == COORD_W'(HMAX - 1));
  assign v_last = (vcnt == COORD_W'(VMAX - 1));

  // Counter stage: strobes are registered from the same wrap condition that
  // resets hcnt, so they line up with the first cycle of the new line/frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hcnt    <= '0;
      vcnt    <= '0;
      fcnt    <= '0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      line_q  <= bus.pixel_ce && h_last;
      frame_q <= bus.pixel_ce && h_last && v_last;
      if (bus.pixel_ce) begin
        if (h_last) begin
          hcnt <= '0;
          if (v_last) begin
            vcnt <= '0;
            fcnt <= fcnt + FCNT_W'(1);
          end else begin
            vcnt <= vcnt + COORD_W'(1);
          end
        end else begin
          hcnt <= hcnt + COORD_W'(1);
        end
      end
    end
  end

  // Raw decode: combinational from the current coordinate.
  always_comb begin
    sync_raw.hsync = (int'(hcnt) >= HFP && int'(hcnt) < HSP) ? HSPP : ~HSPP;
    sync_raw.vsync = (int'(vcnt) >= VFP && int'(vcnt) < VSP) ? VSPP : ~VSPP;
    sync_raw.de    = (int'(hcnt) < HSIZE) && (int'(vcnt) < VSIZE);
  end

  // Delay stage: advances with the counters so sync tracks pixel steps.
  vga_sync_delay #(
    .STAGES  (SYNC_DELAY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (bus.pixel_ce),
    .din     (sync_raw),
    .dout    (sync_dly)
  );

  assign bus.hdata       = hcnt;
  assign bus.vdata       = vcnt;
  assign bus.hsync       = sync_dly.hsync;
  assign bus.vsync       = sync_dly.vsync;
  assign bus.data_enable = sync_dly.de;
  assign bus.line_start  = line_q;
  assign bus.frame_start = frame_q;
  assign bus.frame_count = fcnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Three instances share one clock:
//   u_s0 : small timing (8x6), SYNC_DELAY=0
//   u_s2 : small timing (8x6), SYNC_DELAY=2
//   u_t  : 1x1 raster (one clk per frame) so frame_count rollover is reachable
// The model describes every output from n = number of pixel advances since
// reset: position is n mod the raster size, sync is the raw decode of
// position n-SYNC_DELAY, strobes mark an advance that lands on hdata=0.
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct {
    int hsize, hfp, hsp, hmax, vsize, vfp, vsp, vmax, dly;
  } cfg_t;

  typedef struct packed {
    logic [31:0] h, v, hs, vs, de, ls, fs, fc;
  } exp_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic ce      = 1'b0;
  logic rst_t   = 1'b0;
  logic ce_t    = 1'b0;
  bit   chk_en  = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if if_s0 ();
  vga_timing_gen_if if_s2 ();
  vga_timing_gen_if if_t  ();

  assign if_s0.pixel_ce = ce;
  assign if_s2.pixel_ce = ce;
  assign if_t.pixel_ce  = ce_t;

  vga_timing_gen #(.HSIZE(4), .HFP(5), .HSP(6), .HMAX(8), .VSIZE(3), .VFP(4),
                   .VSP(5), .VMAX(6), .HSPP(1'b1), .VSPP(1'b1), .SYNC_DELAY(0))
    u_s0 (.clk(clk), .reset_n(rst_n), .bus(if_s0));

  vga_timing_gen #(.HSIZE(4), .HFP(5), .HSP(6), .HMAX(8), .VSIZE(3), .VFP(4),
                   .VSP(5), .VMAX(6), .HSPP(1'b1), .VSPP(1'b1), .SYNC_DELAY(2))
    u_s2 (.clk(clk), .reset_n(rst_n), .bus(if_s2));

  vga_timing_gen #(.HSIZE(0), .HFP(0), .HSP(1), .HMAX(1), .VSIZE(0), .VFP(0),
                   .VSP(1), .VMAX(1), .HSPP(1'b1), .VSPP(1'b1), .SYNC_DELAY(0))
    u_t (.clk(clk), .reset_n(rst_t), .bus(if_t));

  cfg_t   cfg [3];
  longint n   [3];
  bit     adv [3];
  exp_t   act [3];
  exp_t   exv;

  initial begin
    cfg[0] = '{hsize:4, hfp:5, hsp:6, hmax:8, vsize:3, vfp:4, vsp:5, vmax:6, dly:0};
    cfg[1] = '{hsize:4, hfp:5, hsp:6, hmax:8, vsize:3, vfp:4, vsp:5, vmax:6, dly:2};
    cfg[2] = '{hsize:0, hfp:0, hsp:1, hmax:1, vsize:0, vfp:0, vsp:1, vmax:1, dly:0};
  end

  function automatic exp_t model(cfg_t c, longint cnt, bit advanced);
    exp_t   e;
    longint hh, vv, m;
    hh   = cnt % c.hmax;
    vv   = (cnt / c.hmax) % c.vmax;
    e.h  = 32'(hh);
    e.v  = 32'(vv);
    e.fc = 32'((cnt / (c.hmax * c.vmax)) % 65536);
    e.ls = (advanced && hh == 0) ? 1 : 0;
    e.fs = (advanced && hh == 0 && vv == 0) ? 1 : 0;
    if (cnt >= c.dly) begin
      m    = cnt - c.dly;
      hh   = m % c.hmax;
      vv   = (m / c.hmax) % c.vmax;
      e.hs = (hh >= c.hfp && hh < c.hsp) ? 1 : 0;
      e.vs = (vv >= c.vfp && vv < c.vsp) ? 1 : 0;
      e.de = (hh < c.hsize && vv < c.vsize) ? 1 : 0;
    end else begin
      e.hs = 0;
      e.vs = 0;
      e.de = 0;
    end
    return e;
  endfunction

  // Model state: pixel advances since the last reset edge.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic r, c;
      r = (i == 2) ? rst_t : rst_n;
      c = (i == 2) ? ce_t  : ce;
      if (!r) begin
        n[i]   <= 0;
        adv[i] <= 1'b0;
      end else if (c) begin
        n[i]   <= n[i] + 1;
        adv[i] <= 1'b1;
      end else begin
        adv[i] <= 1'b0;
      end
    end
  end

  // Per-cycle compare of all three instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      act[0] = '{h: 32'(if_s0.hdata), v: 32'(if_s0.vdata), hs: 32'(if_s0.hsync),
                 vs: 32'(if_s0.vsync), de: 32'(if_s0.data_enable),
                 ls: 32'(if_s0.line_start), fs: 32'(if_s0.frame_start),
                 fc: 32'(if_s0.frame_count)};
      act[1] = '{h: 32'(if_s2.hdata), v: 32'(if_s2.vdata), hs: 32'(if_s2.hsync),
                 vs: 32'(if_s2.vsync), de: 32'(if_s2.data_enable),
                 ls: 32'(if_s2.line_start), fs: 32'(if_s2.frame_start),
                 fc: 32'(if_s2.frame_count)};
      act[2] = '{h: 32'(if_t.hdata), v: 32'(if_t.vdata), hs: 32'(if_t.hsync),
                 vs: 32'(if_t.vsync), de: 32'(if_t.data_enable),
                 ls: 32'(if_t.line_start), fs: 32'(if_t.frame_start),
                 fc: 32'(if_t.frame_count)};
      for (int i = 0; i < 3; i++) begin
        exv = model(cfg[i], n[i], adv[i]);
        checks++;
        if (act[i] !== exv) begin
          failures++;
          if (failures < 30)
            $display("FAIL model[%0d] t=%0t got h=%0d v=%0d hs=%0d vs=%0d de=%0d ls=%0d fs=%0d fc=%0d need h=%0d v=%0d hs=%0d vs=%0d de=%0d ls=%0d fs=%0d fc=%0d",
                     i, $time, act[i].h, act[i].v, act[i].hs, act[i].vs, act[i].de,
                     act[i].ls, act[i].fs, act[i].fc, exv.h, exv.v, exv.hs, exv.vs,
                     exv.de, exv.ls, exv.fs, exv.fc);
        end
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint need);
    checks++;
    if (got !== need) begin
      failures++;
      $display("FAIL %s: got %0d need %0d", name, got, need);
    end
  endtask

  int     hs0, vs0, de0, hs_bad, vs_bad, hs2, hs2_bad, ls_cnt;
  int     fs_at [$];
  bit     found;

  initial begin
    hs0 = 0; vs0 = 0; de0 = 0; hs_bad = 0; vs_bad = 0; hs2 = 0; hs2_bad = 0; ls_cnt = 0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    // Reset state
    chk("rst_hdata", if_s2.hdata, 0);
    chk("rst_vdata", if_s2.vdata, 0);
    chk("rst_hsync", if_s2.hsync, 0);
    chk("rst_vsync", if_s2.vsync, 0);
    chk("rst_de",    if_s2.data_enable, 0);
    chk("rst_fc",    if_s2.frame_count, 0);
    chk("rst_ls",    if_s2.line_start, 0);
    chk("rst_fs",    if_s2.frame_start, 0);

    // Three frames, pixel_ce tied high
    rst_n = 1'b1;
    ce    = 1'b1;
    for (int k = 1; k <= 144; k++) begin
      @(negedge clk);
      if (if_s0.frame_start) fs_at.push_back(k);
      if (k <= 48) begin
        if (if_s0.hsync) begin hs0++; if (if_s0.hdata != 5) hs_bad++; end
        if (if_s0.vsync) begin vs0++; if (if_s0.vdata != 4) vs_bad++; end
        if (if_s0.data_enable) de0++;
        if (if_s2.hsync) begin hs2++; if (if_s2.hdata != 7) hs2_bad++; end
      end
      if (k == 3) chk("s0_de_k3", if_s0.data_enable, 1);
      if (k == 4) chk("s0_de_k4", if_s0.data_enable, 0);
      if (k == 5) chk("s2_de_k5", if_s2.data_enable, 1);
      if (k == 6) chk("s2_de_k6", if_s2.data_enable, 0);
      if (k == 7) chk("s0_hdata_k7", if_s0.hdata, 7);
      if (k == 8) begin
        chk("s0_hdata_wrap", if_s0.hdata, 0);
        chk("s0_ls_k8", if_s0.line_start, 1);
      end
      if (k == 48) chk("s0_ls_with_fs", if_s0.line_start, 1);
    end
    chk("hs_per_frame", hs0, 6);
    chk("hs_wrong_hdata", hs_bad, 0);
    chk("vs_per_frame", vs0, 8);
    chk("vs_wrong_vdata", vs_bad, 0);
    chk("de_per_frame", de0, 12);
    chk("s2_hs_per_frame", hs2, 6);
    chk("s2_hs_not_at_7", hs2_bad, 0);
    chk("fs_pulses", fs_at.size(), 3);
    if (fs_at.size() == 3) begin
      chk("fs_first", fs_at[0], 48);
      chk("fs_second", fs_at[1], 96);
      chk("fs_third", fs_at[2], 144);
    end
    chk("fc_after_3", if_s0.frame_count, 3);

    // pixel_ce toggling 1,0,1,0 from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      ce = (k % 2 == 1);
      @(negedge clk);
      if (if_s0.line_start) ls_cnt++;
      if (k == 10) chk("toggle_hdata_k10", if_s0.hdata, 5);
      if (k == 15) chk("toggle_ls_k15", if_s0.line_start, 1);
      if (k == 16) chk("toggle_ls_k16", if_s0.line_start, 0);
    end
    chk("toggle_hdata_k20", if_s0.hdata, 2);
    chk("toggle_vdata_k20", if_s0.vdata, 1);
    chk("toggle_ls_count", ls_cnt, 1);

    // Reset mid-frame at (3,2)
    ce    = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (if_s2.hdata == 3 && if_s2.vdata == 2) found = 1'b1;
    end
    chk("reach_3_2", found, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_hdata", if_s2.hdata, 0);
    chk("midrst_vdata", if_s2.vdata, 0);
    chk("midrst_hsync", if_s2.hsync, 0);
    chk("midrst_de",    if_s2.data_enable, 0);
    chk("midrst_fc",    if_s2.frame_count, 0);
    chk("midrst_ls",    if_s2.line_start, 0);
    chk("midrst_fs",    if_s2.frame_start, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_resume", if_s2.hdata, 5);

    // frame_count rollover on the one-clock-per-frame raster
    rst_t = 1'b1;
    ce_t  = 1'b1;
    repeat (65535) @(negedge clk);
    chk("fc_ffff", if_t.frame_count, 16'hFFFF);
    @(negedge clk);
    chk("fc_roll", if_t.frame_count, 0);
    chk("roll_fs", if_t.frame_start, 1);
    chk("roll_ls", if_t.line_start, 1);
    ce_t = 1'b0;
    @(negedge clk);
    chk("hold_ls", if_t.line_start, 0);
    chk("hold_fs", if_t.frame_start, 0);
    chk("hold_fc", if_t.frame_count, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
